input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Conditions one asynchronous, possibly bouncing SPI pad input into the system clock domain.
- Three stages: two-flop synchronizer, counter-based debounce filter, and a single-cycle rising/falling edge detector.
- One instance each sits upstream of the SPI finitestatemachine for sclk, cs and mosi.
- The FSM's clkEdge is the sclk instance's positiveedge; its chipSel is the cs instance's conditioned output.

Parameters:
- WAIT_TIME, 3: consecutive clk cycles the synchronized input must differ from conditioned before conditioned follows it. Legal range 1..2**COUNTER_WIDTH.
- COUNTER_WIDTH, 3: debounce counter width; must represent WAIT_TIME-1.
- RESET_VAL, 0: value of conditioned and both synchronizer flops during reset. Use 0 for sclk/mosi, 1 for cs.

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset; asserts immediately, releases synchronously to clk
- noisysignal  input  1  raw pad input, asynchronous to clk, may glitch
- conditioned  output  1  synchronized, debounced level (registered)
- positiveedge  output  1  one-cycle pulse when conditioned goes 0->1 (registered)
- negativeedge  output  1  one-cycle pulse when conditioned goes 1->0 (registered)

Behaviour:
- Reset (rst_n low, async): sync0=sync1=RESET_VAL, conditioned=RESET_VAL, counter=0, positiveedge=0, negativeedge=0. Applies mid-count and mid-pulse; any pending count is discarded.
- Synchronizer: each posedge, sync0<=noisysignal and sync1<=sync0. Only sync1 feeds the filter.
- Filter, evaluated each posedge:
  - sync1==conditioned: counter<=0, no change.
  - sync1!=conditioned and counter==WAIT_TIME-1: conditioned<=sync1, counter<=0.
  - sync1!=conditioned otherwise: counter<=counter+1.
- Glitch rejection: any cycle with sync1==conditioned clears the counter. A disagreement must persist for WAIT_TIME consecutive sampled cycles to take effect.
- Latency: a stable level change first sampled into sync0 at edge k updates conditioned at edge k+WAIT_TIME+1. For WAIT_TIME=3 that is 4 edges.
- Edge outputs are registered and updated on the same edge conditioned changes:
  - positiveedge<=1 iff conditioned goes 0->1 on that edge, else 0.
  - negativeedge<=1 iff conditioned goes 1->0 on that edge, else 0.
  - Each pulse is high for exactly one clk cycle, coincident with the first cycle of the new conditioned level.
  - positiveedge and negativeedge are never high together.
- Back-to-back transitions: at most one edge pulse per WAIT_TIME cycles. Consecutive pulses are separated by at least WAIT_TIME-1 low cycles (zero when WAIT_TIME=1).
- Post-reset mismatch: if noisysignal differs from RESET_VAL when rst_n releases, conditioned follows after WAIT_TIME+2 edges and emits the matching edge pulse. This is required behaviour, not a fault.
- Counter never exceeds WAIT_TIME-1; no wrap-around is reachable.
- No combinational path from noisysignal to any output.

Test Plan:
- Clean step (WAIT_TIME=3, RESET_VAL=0): release reset with noisysignal=0, raise it to 1 and hold before edge 0 -> conditioned=1 after edge 4; positiveedge=1 for exactly the cycle after edge 4; negativeedge stays 0.
- Glitch rejection: conditioned=0, drive noisysignal 1 for 2 clk cycles then 0 -> conditioned stays 0; both edge outputs stay 0 throughout.
- Threshold: conditioned=0, pulse noisysignal high for exactly 3 sampled cycles -> conditioned rises once; after return to 0 and 3 more stable cycles, one negativeedge pulse follows. Total: one positiveedge and one negativeedge.
- Reset mid-count: noisysignal 0->1, assert rst_n low after 2 edges, release 1 cycle later -> conditioned=0 and edges=0 during reset; conditioned rises only WAIT_TIME+2 edges after release.
- Chip-select instance (RESET_VAL=1): reset with noisysignal=1 -> conditioned=1, no pulse. Drop to 0 -> negativeedge pulse at edge 4, then conditioned=0.
- Square wave with 8-cycle half-period, 30 cycles, WAIT_TIME=3 -> conditioned is the same waveform delayed 4 cycles; exactly one pulse per transition; positiveedge and negativeedge never high together.

Source files
------------

// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects one async pad input; conditioned lags a stable change by WAIT_TIME+1 edges.
// No backpressure: every output is registered and updates every core cycle.
module input_conditioner #(
    parameter int   WAIT_TIME     = 3,
    parameter int   COUNTER_WIDTH = 3,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisysignal,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(WAIT_TIME - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    logic                     sync0_q, sync1_q;
    logic                     cond_q, cond_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     pos_q, pos_d;
    logic                     neg_q, neg_d;

    // Any agreeing sample clears the count, so only an unbroken run of disagreement lands.
    always_comb begin
        cond_d = cond_q;
        cnt_d  = '0;
        if (sync1_q != cond_q) begin
            if (cnt_q == CNT_MAX) begin
                cond_d = sync1_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        pos_d = cond_d & ~cond_q;
        neg_d = ~cond_d & cond_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= RESET_VAL;
            sync1_q <= RESET_VAL;
            cond_q  <= RESET_VAL;
            cnt_q   <= '0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            sync0_q <= noisysignal;
            sync1_q <= sync0_q;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign conditioned  = cond_q;
    assign positiveedge = pos_q;
    assign negativeedge = neg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: data instance (RESET_VAL=0) and chip-select instance (RESET_VAL=1).
module tb_input_conditioner;

    typedef struct {
        logic pos;
        int   cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic na, nb;
    logic cond_a, pos_a, neg_a;
    logic cond_b, pos_b, neg_b;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  qa[$];
    ev_t  qb[$];

    input_conditioner #(.WAIT_TIME(3), .COUNTER_WIDTH(3), .RESET_VAL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .noisysignal(na),
        .conditioned(cond_a), .positiveedge(pos_a), .negativeedge(neg_a)
    );

    input_conditioner #(.WAIT_TIME(3), .COUNTER_WIDTH(3), .RESET_VAL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .noisysignal(nb),
        .conditioned(cond_b), .positiveedge(pos_b), .negativeedge(neg_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input logic pos, input int at);
        ev_t e;
        e.pos = pos;
        e.cyc = at;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic pos, input int at);
        ev_t e;
        e.pos = pos;
        e.cyc = at;
        qb.push_back(e);
    endtask

    // Monitors: every edge pulse the DUT presents is matched against the next expected event.
    always @(negedge clk) begin
        if (pos_a || neg_a) begin
            check("a_excl", int'(pos_a & neg_a), 0);
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected_pulse: pos=%0b neg=%0b at cycle %0d, expected none", pos_a, neg_a, cyc);
            end else begin
                ev_t e;
                e = qa.pop_front();
                check("a_edge_kind", int'(pos_a), int'(e.pos));
                check("a_edge_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (pos_b || neg_b) begin
            check("b_excl", int'(pos_b & neg_b), 0);
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected_pulse: pos=%0b neg=%0b at cycle %0d, expected none", pos_b, neg_b, cyc);
            end else begin
                ev_t e;
                e = qb.pop_front();
                check("b_edge_kind", int'(pos_b), int'(e.pos));
                check("b_edge_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        na    = 1'b0;
        nb    = 1'b1;
        step(2);
        check("rst_a_cond", int'(cond_a), 0);
        check("rst_a_pos", int'(pos_a), 0);
        check("rst_a_neg", int'(neg_a), 0);
        check("rst_b_cond", int'(cond_b), 1);
        check("rst_b_pos", int'(pos_b), 0);
        check("rst_b_neg", int'(neg_b), 0);
        rst_n = 1'b1;
        step(6);
        check("idle_a_cond", int'(cond_a), 0);
        check("idle_b_cond", int'(cond_b), 1);

        // Clean rise and fall: sampled at edge c+1, conditioned changes at edge c+5.
        na = 1'b1;
        push_a(1'b1, cyc + 5);
        step(10);
        check("step_up_cond", int'(cond_a), 1);
        check("step_up_drained", qa.size(), 0);
        na = 1'b0;
        push_a(1'b0, cyc + 5);
        step(10);
        check("step_dn_cond", int'(cond_a), 0);
        check("step_dn_drained", qa.size(), 0);

        // Two-cycle glitch is rejected.
        na = 1'b1;
        step(2);
        na = 1'b0;
        step(8);
        check("glitch_cond", int'(cond_a), 0);

        // Exactly three samples high: one rise, then fall three cycles later.
        na = 1'b1;
        push_a(1'b1, cyc + 5);
        push_a(1'b0, cyc + 8);
        step(3);
        na = 1'b0;
        step(10);
        check("thresh_cond", int'(cond_a), 0);
        check("thresh_drained", qa.size(), 0);

        // Reset mid-count; input still high at release rises five edges later.
        na = 1'b1;
        step(2);
        rst_n = 1'b0;
        #1;
        check("midrst_cond", int'(cond_a), 0);
        check("midrst_pos", int'(pos_a), 0);
        check("midrst_neg", int'(neg_a), 0);
        check("midrst_b_cond", int'(cond_b), 1);
        step(1);
        rst_n = 1'b1;
        push_a(1'b1, cyc + 5);
        step(10);
        check("postrst_cond", int'(cond_a), 1);
        check("postrst_drained", qa.size(), 0);
        na = 1'b0;
        push_a(1'b0, cyc + 5);
        step(10);
        check("postrst_fall_cond", int'(cond_a), 0);

        // Square wave, 8-cycle half period.
        for (int k = 0; k < 4; k++) begin
            na = (k % 2 == 0) ? 1'b1 : 1'b0;
            push_a(na, cyc + 5);
            step(8);
        end
        step(8);
        check("square_cond", int'(cond_a), 0);
        check("square_drained", qa.size(), 0);

        // Chip-select instance: drop then raise.
        nb = 1'b0;
        push_b(1'b0, cyc + 5);
        step(10);
        check("cs_low_cond", int'(cond_b), 0);
        nb = 1'b1;
        push_b(1'b1, cyc + 5);
        step(10);
        check("cs_high_cond", int'(cond_b), 1);
        check("cs_drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
